// File: rtl/uart_tx_buffered_if.sv
// Host-side enqueue handshake for uart_tx_buffered.
// The master offers P_DATA with Data_Valid; the slave accepts while Data_Ready.
interface uart_tx_buffered_if #(
    parameter int DATA_WD = 8
);
    logic [DATA_WD-1:0] P_DATA;
    logic               Data_Valid;
    logic               Data_Ready;

    modport master (
        output P_DATA,
        output Data_Valid,
        input  Data_Ready
    );

    modport slave (
        input  P_DATA,
        input  Data_Valid,
        output Data_Ready
    );
endinterface

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO, runtime prescaler, parity, one/two stop bits.
// Optional line-break support is enabled by defining UART_TX_BREAK_EN.
module uart_tx_buffered #(
    parameter int DATA_WD     = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int PRESCALE_WD = 8
) (
    input  logic                         CLK,
    input  logic                         RST,
    uart_tx_buffered_if.slave            bus,
    input  logic                         PAR_EN,
    input  logic                         PAR_TYP,
    input  logic                         STOP2,
    input  logic [PRESCALE_WD-1:0]       PRESCALE,
`ifdef UART_TX_BREAK_EN
    input  logic                         break_req,
`endif
    output logic                         TX_OUT,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(DATA_WD);
    localparam logic [BW-1:0] LAST = BW'(DATA_WD - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
`ifdef UART_TX_BREAK_EN
        BREAK,
        MARK,
`endif
        STOP
    } state_t;

    logic [DATA_WD-1:0]     mem [FIFO_DEPTH];
    logic [AW:0]            wptr;
    logic [AW:0]            rptr;
    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   pop;
    logic [DATA_WD-1:0]     rd_data;

    state_t                 state;
    logic [PRESCALE_WD-1:0] cnt;
    logic [PRESCALE_WD-1:0] pre_q;
    logic [BW-1:0]          bit_idx;
    logic [DATA_WD-1:0]     shreg;
    logic                   par_bit;
    logic                   pe_q;
    logic                   s2_q;
    logic                   stop_idx;
    logic                   bit_end;
    logic                   stop_end;
    logic                   mark_end;
    logic                   brk;

    assign fifo_count     = wptr - rptr;
    assign full           = fifo_count == (AW+1)'(FIFO_DEPTH);
    assign empty          = wptr == rptr;
    assign bus.Data_Ready = !full;
    assign push           = bus.Data_Valid && !full;
    assign rd_data        = mem[rptr[AW-1:0]];

    assign bit_end  = cnt == pre_q;
    assign stop_end = (state == STOP) && bit_end && (!s2_q || stop_idx);

`ifdef UART_TX_BREAK_EN
    assign brk      = break_req;
    assign mark_end = (state == MARK) && bit_end;
`else
    assign brk      = 1'b0;
    assign mark_end = 1'b0;
`endif

    // A pending break wins over the FIFO only where it is sampled
    assign pop = !empty &&
                 ((((state == IDLE) || stop_end) && !brk) || mark_end);

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= bus.P_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            TX_OUT   <= 1'b1;
            busy     <= 1'b0;
            cnt      <= '0;
            pre_q    <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            pe_q     <= 1'b0;
            s2_q     <= 1'b0;
            stop_idx <= 1'b0;
        end else begin
            cnt <= bit_end ? '0 : cnt + 1'b1;
            if (pop) begin
                // Frame config is frozen here for the whole frame
                state    <= START;
                TX_OUT   <= 1'b0;
                busy     <= 1'b1;
                cnt      <= '0;
                shreg    <= rd_data;
                par_bit  <= (^rd_data) ^ PAR_TYP;
                pe_q     <= PAR_EN;
                s2_q     <= STOP2;
                pre_q    <= PRESCALE;
                stop_idx <= 1'b0;
            end else begin
                unique case (state)
`ifdef UART_TX_BREAK_EN
                    IDLE: begin
                        if (brk) begin
                            state  <= BREAK;
                            TX_OUT <= 1'b0;
                            busy   <= 1'b1;
                        end
                    end
                    BREAK: begin
                        if (!brk) begin
                            state  <= MARK;
                            TX_OUT <= 1'b1;
                            cnt    <= '0;
                            pre_q  <= PRESCALE;
                        end
                    end
                    MARK: begin
                        if (bit_end) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
`endif
                    START: begin
                        if (bit_end) begin
                            state   <= DATA;
                            bit_idx <= '0;
                            TX_OUT  <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            if (bit_idx == LAST) begin
                                if (pe_q) begin
                                    state  <= PARITY;
                                    TX_OUT <= par_bit;
                                end else begin
                                    state  <= STOP;
                                    TX_OUT <= 1'b1;
                                end
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                                TX_OUT  <= shreg[0];
                                shreg   <= shreg >> 1;
                            end
                        end
                    end
                    PARITY: begin
                        if (bit_end) begin
                            state  <= STOP;
                            TX_OUT <= 1'b1;
                        end
                    end
                    STOP: begin
                        if (bit_end) begin
                            if (s2_q && !stop_idx) begin
                                stop_idx <= 1'b1;
                            end else begin
                                stop_idx <= 1'b0;
`ifdef UART_TX_BREAK_EN
                                if (brk) begin
                                    state  <= BREAK;
                                    TX_OUT <= 1'b0;
                                end else
`endif
                                begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                end
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Parametrised UART transmitter, successor to the fixed 8-bit, one-cycle-per-bit transmitter in the UART block. It adds a small transmit FIFO with a valid/ready handshake, a runtime baud prescaler, and selectable one or two stop bits. It sits between the host-side data source and the serial line, and frames each buffered word as start, data (LSB first), optional parity, and stop bits.

## Interface
- DATA_WD, 8, data bits per frame (5..9)
- FIFO_DEPTH, 4, transmit FIFO entries; power of two, ≥ 2
- PRESCALE_WD, 8, width of PRESCALE input
- CLK  in  1  single clock, rising edge
- RST  in  1  reset, synchronous, active-high
- P_DATA  in  DATA_WD  word to enqueue
- Data_Valid  in  1  enqueue request
- Data_Ready  out  1  FIFO not full; a word is accepted on an edge where Data_Valid && Data_Ready
- PAR_EN  in  1  append parity bit
- PAR_TYP  in  1  0 = even, 1 = odd
- STOP2  in  1  0 = one stop bit, 1 = two stop bits
- PRESCALE  in  PRESCALE_WD  bit period = PRESCALE+1 CLK cycles
- TX_OUT  out  1  serial line, idle high
- busy  out  1  frame in progress (state ≠ IDLE)
- fifo_count  out  $clog2(FIFO_DEPTH)+1  words held in the FIFO

## Operation
- FIFO: circular buffer with read and write pointers one bit wider than the address; full/empty are decided from the pointers.
- Push occurs only when Data_Valid && !full. Data_Valid while full is ignored; the source must hold until Data_Ready.
- A push and a pop on the same edge leave fifo_count unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when the FIFO is non-empty. The pop, the latch of the word, and the latch of PAR_EN, PAR_TYP, STOP2 and PRESCALE all happen on the same edge. Changing the config inputs mid-frame has no effect on that frame.
  - START drives 0 for one bit period, then → DATA.
  - DATA drives the latched word LSB first, one bit per period; the bit counter is $clog2(DATA_WD) wide. After bit DATA_WD-1 it goes to PARITY if PAR_EN, else to STOP.
  - PARITY drives ^word for even parity, ~^word for odd, for one period, then → STOP.
  - STOP drives 1 for 1 or 2 periods. At its end: → START (popping the next word) if the FIFO is non-empty, else → IDLE.
- Baud counter counts 0..PRESCALE_latched; a bit ends when the counter equals PRESCALE_latched. PRESCALE=0 gives one cycle per bit.
- TX_OUT is registered.

## Timing
- Reset values: TX_OUT=1, busy=0, Data_Ready=1, fifo_count=0, FSM=IDLE, pointers=0.
- RST asserted mid-frame: on the next edge TX_OUT=1 and the FIFO is flushed. A partial frame is not resumed.
- First-word latency into an empty, idle block:
  - Word accepted at edge k.
  - Pop and start-bit drive at edge k+1; TX_OUT=0 and busy=1 from k+1.
  - Data_Ready reflects the new fifo_count one cycle after each push/pop.
- Frame length = (2 + DATA_WD + PAR_EN + STOP2) × (PRESCALE+1) cycles.
- Back-to-back frames: no idle cycle between the last stop period and the next start bit when the FIFO is non-empty.
- busy falls on the edge that ends the last stop period with the FIFO empty.

## Configuration
- Macro: UART_TX_BREAK_EN.
- Defined:
  - Adds input port break_req (1 bit) and FSM states BREAK and MARK.
  - break_req is sampled only in IDLE and at the end of STOP. If high there, it takes priority over the FIFO: → BREAK, which drives TX_OUT=0 with busy=1 and does not pop.
  - break_req low in BREAK → MARK, which drives 1 for one bit period (current PRESCALE), then normal IDLE/START selection.
- Undefined: the port and both states are absent; behaviour is exactly as above.

## Test plan
- DATA_WD=8, PRESCALE=0, PAR_EN=1, PAR_TYP=0, push 0xA5 → TX_OUT from edge k+1 is 0,1,0,1,0,0,1,0,1,0,1. Then idle high; busy high for exactly 11 cycles.
- PRESCALE=3, PAR_EN=0, STOP2=1, push 0x3C → each bit held 4 cycles, frame 44 cycles, final two stop periods high.
- FIFO_DEPTH=4, PRESCALE=7, push 6 words with Data_Valid held → Data_Ready drops after the 5th accepted word (4 buffered + 1 popped). All 5 words are transmitted back-to-back with no idle gap, in order.
- Push 0x5A with PAR_TYP=1, then change PAR_TYP to 0 and PRESCALE mid-frame → frame 1 uses odd parity bit 1 and the original bit period. The next frame uses the new values.
- Assert RST during DATA bit 3 → next cycle TX_OUT=1, busy=0, fifo_count=0, Data_Ready=1. A following push produces a clean full frame.
- UART_TX_BREAK_EN defined: break_req high for 20 cycles while 2 words are queued → TX_OUT low for the whole hold, then high for one bit period, then both words sent. fifo_count is unchanged during the break.
